// File: rtl/regfile_ctrl_pkg.sv
// ============================================================================
//  Module      : regfile_ctrl_pkg
//  Description : Shared types and default sizes for the register-file write
//                scheduler (state ids, requester ids, widths).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_ctrl_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_NUM_REGS = 32;

  // Scheduler phase: zero-init walk, then writeback arbitration
  typedef enum logic [0:0] {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_e;

  // Requester identity; values double as grant-vector bit positions
  typedef enum logic [0:0] {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage : regfile_ctrl_pkg

`default_nettype wire

// File: rtl/regfile_write_sched_rr_arb2.sv
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. A lone requester always wins;
//                on conflict the requester not granted last time wins. The
//                history only advances when a grant is actually consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  req_id_e r_last_grant;

  // Grant selection: single requester wins, conflict goes to the other side
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (r_last_grant == REQ_MEM) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner of each completed handshake; reset favours ALU next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= REQ_MEM;
    end else if (accept && (grant != 2'b00)) begin
      r_last_grant <= grant[1] ? REQ_MEM : REQ_ALU;
    end
  end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/regfile_write_sched.sv
// ============================================================================
//  Module      : regfile_write_sched
//  Description : Owns the single write port of the register file. Clears
//                every register after reset or clear_req, then arbitrates
//                ALU and MEM writebacks onto the port one per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_sched
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              init_done,
  output logic              wr_err
);

  localparam int CNT_W = $clog2(NUM_REGS) + 1;

  localparam logic [0:0]       ST_INIT   = 1'(INIT);
  localparam logic [0:0]       ST_ARB    = 1'(ARB);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]  REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_arb_en;
  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_idx_zero;
  logic              w_idx_oob;

  // A clear request suppresses arbitration in the cycle it is seen
  assign w_arb_en = (r_state == ST_ARB) && !clear_req;
  assign w_req    = {mem_valid, alu_valid} & {2{w_arb_en}};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (w_req),
    .accept (w_accept),
    .grant  (w_grant)
  );

  // Any grant is a completed handshake since grant only follows a valid
  assign w_accept  = |w_grant;
  assign alu_ready = w_grant[REQ_ALU];
  assign mem_ready = w_grant[REQ_MEM];

  assign w_sel_reg  = w_grant[REQ_MEM] ? mem_reg  : alu_reg;
  assign w_sel_data = w_grant[REQ_MEM] ? mem_data : alu_data;
  assign w_idx_zero = (w_sel_reg == '0);
  assign w_idx_oob  = ({1'b0, w_sel_reg} >= REG_LIMIT);

  assign init_done = (r_state == ST_ARB);

  // Phase control: walk the counter through every register, then arbitrate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (clear_req) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Registered write port: zero writes during the walk, accepted data in ARB;
  // $zero and out-of-range indices complete the handshake but never write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      wr_err     <= 1'b0;
    end else if (r_state == ST_INIT) begin
      reg_write  <= 1'b1;
      write_reg  <= ADDR_W'(r_cnt);
      write_data <= '0;
      wr_err     <= 1'b0;
    end else begin
      reg_write <= w_accept && !w_idx_zero && !w_idx_oob;
      wr_err    <= w_accept && w_idx_oob;
      if (w_accept) begin
        write_reg  <= w_sel_reg;
        write_data <= w_sel_data;
      end
    end
  end

endmodule : regfile_write_sched

`default_nettype wire

// File: tb/tb_regfile_write_sched.sv
// ============================================================================
//  Module      : tb_regfile_write_sched
//  Description : Self-checking bench for regfile_write_sched with directed
//                scenarios and a randomized writeback stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_sched;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_req;
  logic          alu_valid, mem_valid;
  logic [AW-1:0] alu_reg, mem_reg;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready;
  logic          reg_write, init_done, wr_err;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;

  int total = 0;
  int bad   = 0;

  // Reference state: which requester won the last completed handshake (1 = MEM)
  int mdl_last = 1;

  // Observed and expected values of one arbitration cycle
  logic          o_ar, o_mr, o_we, o_err, o_done;
  logic [AW-1:0] o_wr;
  logic [DW-1:0] o_wd;
  logic          e_ar, e_mr, e_we, e_err, e_done;
  logic [AW-1:0] e_wr;
  logic [DW-1:0] e_wd;

  always #5 clk = ~clk;

  regfile_write_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .alu_valid  (alu_valid),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_reg    (mem_reg),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .init_done  (init_done),
    .wr_err     (wr_err)
  );

  // One ARB-phase cycle: apply inputs, predict from the rules, capture results
  task automatic run_cycle(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                           input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                           input logic clr);
    logic acc;
    int   idx;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    clear_req = clr;
    #1;
    o_ar = alu_ready;
    o_mr = mem_ready;
    e_ar = 1'b0;
    e_mr = 1'b0;
    if (!clr) begin
      if (av && mv) begin
        if (mdl_last == 1) e_ar = 1'b1;
        else               e_mr = 1'b1;
      end else begin
        e_ar = av;
        e_mr = mv;
      end
    end
    acc   = e_ar | e_mr;
    idx   = e_ar ? int'(ar) : int'(mr);
    e_we  = acc && (idx != 0) && (idx < NR);
    e_err = acc && (idx >= NR);
    e_wr  = e_ar ? ar : mr;
    e_wd  = e_ar ? ad : md;
    e_done = !clr;
    if (acc) mdl_last = e_mr ? 1 : 0;
    @(posedge clk); #1;
    o_we   = reg_write;
    o_err  = wr_err;
    o_wr   = write_reg;
    o_wd   = write_data;
    o_done = init_done;
  endtask

  // Follow a zero-init walk from its first write up to index stop_at-1;
  // a clear pulse mid-walk must be ignored and readies must stay low
  task automatic walk_check(input int stop_at);
    clear_req = 1'b0;
    for (int i = 0; i < stop_at; i++) begin
      @(posedge clk); #1;
      total++;
      if (reg_write !== 1'b1 || write_reg !== AW'(i) || write_data !== '0) begin
        bad++;
        $display("FAIL walk[%0d]: we=%b reg=%0d data=%h, want we=1 reg=%0d data=0",
                 i, reg_write, write_reg, write_data, i);
      end
      total++;
      if (init_done !== (i == NR - 1)) begin
        bad++;
        $display("FAIL walk_done[%0d]: init_done=%b want %b", i, init_done, (i == NR - 1));
      end
      if (i < NR - 1) begin
        total++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
          bad++;
          $display("FAIL walk_ready[%0d]: alu_ready=%b mem_ready=%b want 0 0",
                   i, alu_ready, mem_ready);
        end
      end
      clear_req = (i == 10);
    end
    clear_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear_req = 1'b0;
    alu_valid = 1'b1; alu_reg = 6'd3; alu_data = 32'h1;
    mem_valid = 1'b1; mem_reg = 6'd4; mem_data = 32'h2;
    @(posedge clk); #1;
    total++;
    if (reg_write !== 1'b0 || write_reg !== '0 || write_data !== '0 ||
        init_done !== 1'b0 || wr_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: we=%b reg=%0d data=%h done=%b err=%b, want all 0",
               reg_write, write_reg, write_data, init_done, wr_err);
    end
    total++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: alu_ready=%b mem_ready=%b want 0 0", alu_ready, mem_ready);
    end
    rst_n = 1'b1;
    mdl_last = 1;
    walk_check(NR);
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_conflict;
    int exp_wr[4] = '{1, 9, 2, 10};
    int an = 0;
    int mn = 0;
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b1, AW'(1 + an), DW'(32'h100 + an), 1'b1, AW'(9 + mn), DW'(32'h900 + mn), 1'b0);
      total++;
      if (o_ar !== (k % 2 == 0) || o_mr !== (k % 2 == 1)) begin
        bad++;
        $display("FAIL conflict_grant[%0d]: alu_ready=%b mem_ready=%b want %b %b",
                 k, o_ar, o_mr, (k % 2 == 0), (k % 2 == 1));
      end
      total++;
      if (o_we !== 1'b1 || o_wr !== AW'(exp_wr[k]) || o_wd !== e_wd) begin
        bad++;
        $display("FAIL conflict_write[%0d]: we=%b reg=%0d data=%h want 1 %0d %h",
                 k, o_we, o_wr, o_wd, exp_wr[k], e_wd);
      end
      if (k % 2 == 0) an++; else mn++;
    end
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    total++;
    if (o_we !== 1'b0) begin
      bad++;
      $display("FAIL conflict_idle: we=%b want 0", o_we);
    end
  endtask

  task automatic test_alu_only;
    run_cycle(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
    total++;
    if (o_ar !== 1'b1 || o_mr !== 1'b0) begin
      bad++;
      $display("FAIL alu_only_ready: alu_ready=%b mem_ready=%b want 1 0", o_ar, o_mr);
    end
    total++;
    if (o_we !== 1'b1 || o_wr !== 6'd5 || o_wd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL alu_only_write: we=%b reg=%0d data=%h want 1 5 deadbeef", o_we, o_wr, o_wd);
    end
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    total++;
    if (o_we !== 1'b0) begin
      bad++;
      $display("FAIL alu_only_after: we=%b want 0", o_we);
    end
  endtask

  task automatic test_zero_oob;
    run_cycle(1'b1, 6'd0, 32'h12345678, 1'b0, '0, '0, 1'b0);
    total++;
    if (o_ar !== 1'b1 || o_we !== 1'b0 || o_err !== 1'b0) begin
      bad++;
      $display("FAIL zero_reg: ready=%b we=%b err=%b want 1 0 0", o_ar, o_we, o_err);
    end
    run_cycle(1'b0, '0, '0, 1'b1, 6'd40, 32'hCAFE0000, 1'b0);
    total++;
    if (o_mr !== 1'b1 || o_we !== 1'b0 || o_err !== 1'b1) begin
      bad++;
      $display("FAIL oob_reg: ready=%b we=%b err=%b want 1 0 1", o_mr, o_we, o_err);
    end
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    total++;
    if (o_err !== 1'b0 || o_we !== 1'b0) begin
      bad++;
      $display("FAIL oob_pulse: err=%b we=%b want 0 0", o_err, o_we);
    end
  endtask

  task automatic test_clear;
    // ALU wins last so a preserved history must favour MEM after the walk
    run_cycle(1'b1, 6'd2, 32'hA, 1'b0, '0, '0, 1'b0);
    run_cycle(1'b0, '0, '0, 1'b1, 6'd7, 32'h77777777, 1'b1);
    total++;
    if (o_mr !== 1'b0 || o_ar !== 1'b0) begin
      bad++;
      $display("FAIL clear_ready: alu_ready=%b mem_ready=%b want 0 0", o_ar, o_mr);
    end
    total++;
    if (o_done !== 1'b0 || o_we !== 1'b0) begin
      bad++;
      $display("FAIL clear_state: init_done=%b we=%b want 0 0", o_done, o_we);
    end
    walk_check(NR);
    run_cycle(1'b1, 6'd11, 32'hB, 1'b1, 6'd7, 32'h77777777, 1'b0);
    total++;
    if (o_mr !== 1'b1 || o_ar !== 1'b0 || o_we !== 1'b1 || o_wr !== 6'd7 ||
        o_wd !== 32'h77777777) begin
      bad++;
      $display("FAIL clear_resume: mem_ready=%b alu_ready=%b we=%b reg=%0d data=%h want 1 0 1 7 77777777",
               o_mr, o_ar, o_we, o_wr, o_wd);
    end
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_random;
    logic          ap = 1'b0, mp = 1'b0, clr;
    logic [AW-1:0] ar = '0, mr = '0;
    logic [DW-1:0] ad = '0, md = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ap && ($urandom_range(2) != 0)) begin
        ap = 1'b1; ar = AW'($urandom_range(47)); ad = $urandom;
      end
      if (!mp && ($urandom_range(2) != 0)) begin
        mp = 1'b1; mr = AW'($urandom_range(47)); md = $urandom;
      end
      clr = ($urandom_range(79) == 0);
      run_cycle(ap, ar, ad, mp, mr, md, clr);
      total++;
      if (o_ar !== e_ar || o_mr !== e_mr) begin
        bad++;
        $display("FAIL rand_ready[%0d]: alu_ready=%b mem_ready=%b want %b %b", n, o_ar, o_mr, e_ar, e_mr);
      end
      total++;
      if (o_we !== e_we || o_err !== e_err || o_done !== e_done) begin
        bad++;
        $display("FAIL rand_ctrl[%0d]: we=%b err=%b done=%b want %b %b %b",
                 n, o_we, o_err, o_done, e_we, e_err, e_done);
      end
      if (e_we) begin
        total++;
        if (o_wr !== e_wr || o_wd !== e_wd) begin
          bad++;
          $display("FAIL rand_write[%0d]: reg=%0d data=%h want %0d %h", n, o_wr, o_wd, e_wr, e_wd);
        end
      end
      if (e_ar) ap = 1'b0;
      if (e_mr) mp = 1'b0;
      if (clr) walk_check(NR);
    end
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset_mid_walk;
    // Leave ALU as last winner so the post-reset conflict proves the history reset
    run_cycle(1'b1, 6'd8, 32'h8, 1'b0, '0, '0, 1'b0);
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    walk_check(18);
    rst_n = 1'b0;
    #1;
    total++;
    if (reg_write !== 1'b0 || write_reg !== '0 || write_data !== '0 || init_done !== 1'b0) begin
      bad++;
      $display("FAIL midwalk_reset: we=%b reg=%0d data=%h done=%b want all 0",
               reg_write, write_reg, write_data, init_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_last = 1;
    walk_check(NR);
    run_cycle(1'b1, 6'd3, 32'h33, 1'b1, 6'd4, 32'h44, 1'b0);
    total++;
    if (o_ar !== 1'b1 || o_mr !== 1'b0 || o_wr !== 6'd3) begin
      bad++;
      $display("FAIL midwalk_grant: alu_ready=%b mem_ready=%b reg=%0d want 1 0 3", o_ar, o_mr, o_wr);
    end
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_conflict;
    test_alu_only;
    test_zero_oob;
    test_clear;
    test_random;
    test_reset_mid_walk;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_write_sched

`default_nettype wire
